// File: rtl/vga_source_mux.sv
// Frame-aligned VGA pixel source mux (RGB or one of NUM_MONO mono channels), packed to 16 bits; VGA_SOURCE_MUX_RGB565_EN selects 5-6-5 RGB packing.
// One-cycle registered latency; no backpressure, every wr_en cycle is a push to the frame-buffer FIFO.
module vga_source_mux #(
    parameter int NUM_MONO     = 3,
    parameter int COMP_W       = 12,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic                  pixel_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2:0]            sel,
    input  logic [COMP_W-1:0]     rgb_red,
    input  logic [COMP_W-1:0]     rgb_green,
    input  logic [COMP_W-1:0]     rgb_blue,
    input  logic                  rgb_valid,
    input  logic [8*NUM_MONO-1:0] mono_data,
    input  logic [NUM_MONO-1:0]   mono_valid,
    output logic [15:0]           wr_data,
    output logic                  wr_en,
    output logic                  rgb_mode,
    output logic                  frame_done,
    output logic                  sel_err
);

    localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_active_sel;

    logic        w_sel_ok;
    logic        w_act_vld;
    logic [15:0] w_act_pix;
    logic [15:0] w_rgb_pix;
    logic        w_unused_lsbs;

    assign w_sel_ok = (sel <= 3'(NUM_MONO));

`ifdef VGA_SOURCE_MUX_RGB565_EN
    assign w_rgb_pix = {rgb_red[COMP_W-1 -: 5], rgb_green[COMP_W-1 -: 6], rgb_blue[COMP_W-1 -: 5]};
`else
    assign w_rgb_pix = {1'b0, rgb_red[COMP_W-1 -: 5], rgb_green[COMP_W-1 -: 5], rgb_blue[COMP_W-1 -: 5]};
`endif

    // Only the top component bits reach the packed pixel.
    assign w_unused_lsbs = ^{rgb_red, rgb_green, rgb_blue};

    always_comb begin
        w_act_vld = rgb_valid;
        w_act_pix = w_rgb_pix;
        for (int k = 0; k < NUM_MONO; k++) begin
            if (r_active_sel == 3'(k + 1)) begin
                w_act_vld = mono_valid[k];
                w_act_pix = {8'h00, mono_data[8*k +: 8]};
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_active_sel <= 3'd0;
            wr_en        <= 1'b0;
            wr_data      <= 16'h0000;
            rgb_mode     <= 1'b1;
            frame_done   <= 1'b0;
            sel_err      <= 1'b0;
        end else begin
            if (!w_sel_ok) begin
                sel_err <= 1'b1;
            end
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable && w_sel_ok) begin
                        r_active_sel <= sel;
                        r_cnt        <= '0;
                        r_state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_act_vld) begin
                        wr_en    <= 1'b1;
                        wr_data  <= w_act_pix;
                        rgb_mode <= (r_active_sel == 3'd0);
                        // sel is only sampled at the frame boundary.
                        if (r_cnt == LAST_PIX) begin
                            frame_done <= 1'b1;
                            r_cnt      <= '0;
                            if (enable && w_sel_ok) begin
                                r_active_sel <= sel;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
